score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//   Game-flow controller for pong. Sequences serve / play / point / game-over.
//   Owns the two score registers that feed the score overlay (PLAYER_ONE/PLAYER_TWO).
//   Gates ball motion and selects the serve direction.
//   Sits between the ball/collision logic (point pulses in) and the score/ball renderers.
// PARAMETERS
//   WIN_SCORE     8'd9   points needed to win; default keeps scores single-digit
//   SERVE_FRAMES  60     frame ticks the ball is held before each serve
//   HOLD_FRAMES   30     frame ticks of pause after a point, before the next serve
//   CNT_W         8      width of the frame countdown; must hold max(SERVE_FRAMES,HOLD_FRAMES)
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   START       in   1  one-cycle pulse: start or restart the game
//   FRAME_TICK  in   1  one-cycle pulse, once per video frame
//   P1_POINT    in   1  one-cycle pulse: ball left via player two's edge, point to P1
//   P2_POINT    in   1  one-cycle pulse: point to P2
//   PLAYER_ONE  out  8  P1 score, binary
//   PLAYER_TWO  out  8  P2 score, binary
//   BALL_EN     out  1  1 = ball may move (PLAY state only)
//   SERVE_DIR   out  1  0 = serve toward P1 side, 1 = toward P2 side
//   GAME_OVER   out  1  1 while in OVER state
//   WINNER      out  1  0 = P1 won, 1 = P2 won; valid while GAME_OVER=1
// BEHAVIOUR
//   All outputs registered; all state changes on rising clk.
//   reset: state=IDLE; scores=0; countdown=0; BALL_EN=0; SERVE_DIR=0; GAME_OVER=0; WINNER=0.
//   States:
//   - IDLE: scores held.
//       START -> clear scores, load countdown=SERVE_FRAMES, go to SERVE.
//   - SERVE: BALL_EN=0.
//       countdown==0 -> PLAY on the next edge.
//       Otherwise decrement on each FRAME_TICK.
//   - PLAY: BALL_EN=1.
//       P1_POINT alone: PLAYER_ONE+1, SERVE_DIR<=1.
//       P2_POINT alone: PLAYER_TWO+1, SERVE_DIR<=0.
//       Scores and the new state are visible the cycle after the pulse.
//       New score meets win rule -> OVER, WINNER=scorer.
//       Otherwise -> POINT with countdown=HOLD_FRAMES.
//   - POINT: BALL_EN=0. Countdown as in SERVE.
//       At 0, load SERVE_FRAMES and go to SERVE.
//   - OVER: GAME_OVER=1, BALL_EN=0; scores frozen.
//       START -> clear scores, GAME_OVER=0, go to SERVE.
//   Boundary conditions:
//   - P1_POINT & P2_POINT in the same cycle in PLAY: no score change, SERVE_DIR unchanged,
//     go to POINT (replay).
//   - Point pulses outside PLAY are ignored.
//   - START in SERVE, PLAY or POINT restarts the game: clear scores, go to SERVE,
//     countdown=SERVE_FRAMES. START has priority over a same-cycle point.
//   - FRAME_TICK coincident with countdown==0: the transition wins; no wrap to all-ones.
//   - reset mid-game overrides everything and returns to IDLE in one cycle.
//   Arithmetic:
//   - Scores are unsigned 8-bit and saturate at 8'd99; the countdown never underflows.
//   - Win rule: scorer's new score == WIN_SCORE.
// CONFIGURATION
//   `define SCORE_WIN_BY_TWO_EN
//   Defined:
//   - Win rule becomes: scorer's score >= WIN_SCORE and scorer leads by >= 2.
//   - A point that would take a score past 99 instead ends the game, with the scorer as WINNER.
//   Undefined:
//   - Win rule is the plain == WIN_SCORE test.
//   - Lead is not examined; no win-by-two logic is synthesised.
// TESTING
//   1 Reset: assert reset 2 cycles -> PLAYER_ONE=PLAYER_TWO=0, BALL_EN=0, GAME_OVER=0,
//     SERVE_DIR=0.
//   2 Serve: SERVE_FRAMES=2, START, then 2 FRAME_TICKs -> BALL_EN=1 exactly 2 cycles
//     after the 2nd tick.
//   3 Win: 9 P1_POINT pulses, one per PLAY phase -> PLAYER_ONE=9, GAME_OVER=1, WINNER=0,
//     BALL_EN=0. A further P2_POINT leaves PLAYER_TWO=0.
//   4 Tie pulse: P1_POINT and P2_POINT together in PLAY -> scores unchanged, BALL_EN=0
//     next cycle, SERVE_DIR unchanged.
//   5 Ignore/restart: P2_POINT during SERVE -> no change. START mid-PLAY at 3-2 ->
//     scores 0-0, state SERVE.
//   6 SCORE_WIN_BY_TWO_EN: reach P1 9, P2 8 -> GAME_OVER=0. Next P1 point (10-8) ->
//     GAME_OVER=1, WINNER=0.

Source files
------------

// File: rtl/score_keeper.sv
// Pong game-flow controller: serve / play / point / game-over sequencing and score registers.
// Optional build macro SCORE_WIN_BY_TWO_EN selects the win-by-two rule with overflow-ends-game.
module score_keeper #(
    parameter logic [7:0] WIN_SCORE    = 8'd9,
    parameter int         SERVE_FRAMES = 60,
    parameter int         HOLD_FRAMES  = 30,
    parameter int         CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       START,
    input  logic       FRAME_TICK,
    input  logic       P1_POINT,
    input  logic       P2_POINT,
    output logic [7:0] PLAYER_ONE,
    output logic [7:0] PLAYER_TWO,
    output logic       BALL_EN,
    output logic       SERVE_DIR,
    output logic       GAME_OVER,
    output logic       WINNER
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       p1_s, p2_s, p1_inc_s, p2_inc_s;
    logic             dir_s, winner_s, p1_win_s, p2_win_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= 8'd99) ? 8'd99 : v + 8'd1;
    endfunction

    // Candidate scores and whether a sole point to each player ends the game
    always_comb begin
        p1_inc_s = sat_inc(PLAYER_ONE);
        p2_inc_s = sat_inc(PLAYER_TWO);
`ifdef SCORE_WIN_BY_TWO_EN
        // A score already at 99 cannot grow, so the next point decides the game outright
        p1_win_s = (PLAYER_ONE == 8'd99) ||
                   ((p1_inc_s >= WIN_SCORE) && ({1'b0, p1_inc_s} >= ({1'b0, PLAYER_TWO} + 9'd2)));
        p2_win_s = (PLAYER_TWO == 8'd99) ||
                   ((p2_inc_s >= WIN_SCORE) && ({1'b0, p2_inc_s} >= ({1'b0, PLAYER_ONE} + 9'd2)));
`else
        p1_win_s = (p1_inc_s == WIN_SCORE);
        p2_win_s = (p2_inc_s == WIN_SCORE);
`endif
    end

    // Next-state and next-register values; START restarts the game from any state
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        p1_s     = PLAYER_ONE;
        p2_s     = PLAYER_TWO;
        dir_s    = SERVE_DIR;
        winner_s = WINNER;
        if (START) begin
            p1_s    = 8'd0;
            p2_s    = 8'd0;
            cnt_s   = SERVE_LD;
            state_s = ST_SERVE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SERVE, ST_POINT: begin
                    if (cnt_r == '0) begin
                        if (state_r == ST_SERVE) begin
                            state_s = ST_PLAY;
                        end else begin
                            cnt_s   = SERVE_LD;
                            state_s = ST_SERVE;
                        end
                    end else if (FRAME_TICK) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_PLAY: begin
                    if (P1_POINT && P2_POINT) begin
                        cnt_s   = HOLD_LD;
                        state_s = ST_POINT;
                    end else if (P1_POINT) begin
                        p1_s  = p1_inc_s;
                        dir_s = 1'b1;
                        if (p1_win_s) begin
                            winner_s = 1'b0;
                            state_s  = ST_OVER;
                        end else begin
                            cnt_s   = HOLD_LD;
                            state_s = ST_POINT;
                        end
                    end else if (P2_POINT) begin
                        p2_s  = p2_inc_s;
                        dir_s = 1'b0;
                        if (p2_win_s) begin
                            winner_s = 1'b1;
                            state_s  = ST_OVER;
                        end else begin
                            cnt_s   = HOLD_LD;
                            state_s = ST_POINT;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    state_s = ST_OVER;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, countdown and all outputs registered together from the next-state values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            PLAYER_ONE <= 8'd0;
            PLAYER_TWO <= 8'd0;
            BALL_EN    <= 1'b0;
            SERVE_DIR  <= 1'b0;
            GAME_OVER  <= 1'b0;
            WINNER     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            PLAYER_ONE <= p1_s;
            PLAYER_TWO <= p2_s;
            BALL_EN    <= (state_s == ST_PLAY);
            SERVE_DIR  <= dir_s;
            GAME_OVER  <= (state_s == ST_OVER);
            WINNER     <= winner_s;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed game scenarios plus random play, every
// cycle compared against a phase/score reference model.
module tb_score_keeper;

    localparam int         SF  = 2;
    localparam int         HF  = 1;
    localparam logic [7:0] WIN = 8'd9;

    logic       clk = 1'b0;
    logic       reset, start, tick, p1, p2;
    logic [7:0] player_one, player_two;
    logic       ball_en, serve_dir, game_over, winner;

    always #5 clk = ~clk;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .HOLD_FRAMES(HF), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .START(start), .FRAME_TICK(tick),
        .P1_POINT(p1), .P2_POINT(p2),
        .PLAYER_ONE(player_one), .PLAYER_TWO(player_two), .BALL_EN(ball_en),
        .SERVE_DIR(serve_dir), .GAME_OVER(game_over), .WINNER(winner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: game phase, scores and frames left before the phase ends
    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_p1 = 0, m_p2 = 0, m_wait = 0;
    bit      m_dir = 1'b0, m_win = 1'b0;

    task automatic award(input bit to_p1);
        int  mine, other;
        bit  won;
        mine  = to_p1 ? m_p1 : m_p2;
        other = to_p1 ? m_p2 : m_p1;
        m_dir = to_p1;
`ifdef SCORE_WIN_BY_TWO_EN
        if (mine == 99) won = 1'b1;
        else begin
            mine = mine + 1;
            won  = (mine >= int'(WIN)) && (mine - other >= 2);
        end
`else
        mine = (mine >= 99) ? 99 : mine + 1;
        won  = (mine == int'(WIN));
`endif
        if (to_p1) m_p1 = mine; else m_p2 = mine;
        if (won) begin
            m_phase = M_OVER;
            m_win   = !to_p1;
        end else begin
            m_phase = M_POINT;
            m_wait  = HF;
        end
    endtask

    task automatic model_step(input bit rs, input bit st, input bit ft, input bit a, input bit b);
        if (rs) begin
            m_phase = M_IDLE; m_p1 = 0; m_p2 = 0; m_wait = 0; m_dir = 1'b0; m_win = 1'b0;
        end else if (st) begin
            m_p1 = 0; m_p2 = 0; m_phase = M_SERVE; m_wait = SF;
        end else begin
            case (m_phase)
                M_SERVE, M_POINT: begin
                    if (m_wait == 0) begin
                        if (m_phase == M_SERVE) m_phase = M_PLAY;
                        else begin m_phase = M_SERVE; m_wait = SF; end
                    end else if (ft) m_wait = m_wait - 1;
                end
                M_PLAY: begin
                    if (a && b) begin m_phase = M_POINT; m_wait = HF; end
                    else if (a || b) award(a);
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit rs, input bit st, input bit ft, input bit a, input bit b);
        reset = rs; start = st; tick = ft; p1 = a; p2 = b;
        @(posedge clk);
        model_step(rs, st, ft, a, b);
        #1;
        check_eq("player_one", 32'(player_one), 32'(m_p1));
        check_eq("player_two", 32'(player_two), 32'(m_p2));
        check_eq("ball_en",    32'(ball_en),    32'(m_phase == M_PLAY));
        check_eq("game_over",  32'(game_over),  32'(m_phase == M_OVER));
        check_eq("serve_dir",  32'(serve_dir),  32'(m_dir));
        if (m_phase == M_OVER) check_eq("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic wait_play();
        for (int i = 0; i < 100 && ball_en !== 1'b1; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("reach_play", 32'(ball_en), 32'd1);
    endtask

    task automatic point(input bit a, input bit b);
        wait_play();
        cyc(1'b0, 1'b0, 1'b0, a, b);
    endtask

    bit dir_before;

    initial begin
        // Reset held for two cycles
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_p1", 32'(player_one), 32'd0);
        check_eq("rst_p2", 32'(player_two), 32'd0);
        check_eq("rst_ball", 32'(ball_en), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_dir", 32'(serve_dir), 32'd0);

        // Serve hold: two ticks, ball released on the second cycle after the last tick
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("serve_hold", 32'(ball_en), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("serve_release", 32'(ball_en), 32'd1);

        // Nine points to P1 ends the game; later points are ignored
        for (int k = 0; k < 9; k++) point(1'b1, 1'b0);
        check_eq("win_p1", 32'(player_one), 32'd9);
        check_eq("win_over", 32'(game_over), 32'd1);
        check_eq("win_winner", 32'(winner), 32'd0);
        check_eq("win_ball", 32'(ball_en), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("over_p2_ignored", 32'(player_two), 32'd0);

        // Simultaneous points replay without scoring
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        point(1'b0, 1'b1);
        point(1'b1, 1'b1);
        check_eq("tie_ball", 32'(ball_en), 32'd0);
        check_eq("tie_p1", 32'(player_one), 32'd0);
        check_eq("tie_p2", 32'(player_two), 32'd1);
        check_eq("tie_dir", 32'(serve_dir), 32'd0);
        wait_play();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dir_before = serve_dir;
        point(1'b1, 1'b1);
        check_eq("tie_dir_kept", 32'(serve_dir), 32'(dir_before));

        // Point during SERVE ignored; START at 3-2 with a same-cycle point restarts
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("serve_ignore", 32'(player_two), 32'd0);
        point(1'b1, 1'b0); point(1'b0, 1'b1); point(1'b1, 1'b0);
        point(1'b0, 1'b1); point(1'b1, 1'b0);
        check_eq("pre_restart_p1", 32'(player_one), 32'd3);
        check_eq("pre_restart_p2", 32'(player_two), 32'd2);
        wait_play();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("restart_p1", 32'(player_one), 32'd0);
        check_eq("restart_p2", 32'(player_two), 32'd0);
        check_eq("restart_ball", 32'(ball_en), 32'd0);

`ifdef SCORE_WIN_BY_TWO_EN
        // Win by two: 9-8 continues, 10-8 ends with P1 winning
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            point(1'b1, 1'b0);
            point(1'b0, 1'b1);
        end
        point(1'b1, 1'b0);
        check_eq("wb2_9_8_over", 32'(game_over), 32'd0);
        point(1'b1, 1'b0);
        check_eq("wb2_10_8_p1", 32'(player_one), 32'd10);
        check_eq("wb2_10_8_over", 32'(game_over), 32'd1);
        check_eq("wb2_10_8_winner", 32'(winner), 32'd0);
`endif

        // Random play, including stray pulses, restarts and occasional reset
        for (int i = 0; i < 20000; i++) begin
            cyc($urandom_range(999) == 0, $urandom_range(299) == 0, 1'($urandom_range(1)),
                $urandom_range(5) == 0, $urandom_range(5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
